// File: rtl/brownout_supervisor.sv
// brownout_supervisor
// Digital side of the brown-out detector. It drives the macro's enable and trip
// codes. It synchronises and debounces the macro's asynchronous flags. It holds
// the system in reset through a brown-out and keeps sticky status plus a
// saturating event count for firmware.
// Optional build macro: BROWNOUT_VUNDER_RESET_EN.
// When defined, a debounced undervoltage flag also forces a brown-out, and
// recovery additionally needs vunder low.
module brownout_supervisor #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int ARM_CYCLES      = 64,
    parameter int HOLD_CYCLES     = 1024,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             cfg_ena,
    input  logic [2:0]       cfg_otrip,
    input  logic [2:0]       cfg_vtrip,
    input  logic             status_clr,
    input  logic             outb,
    input  logic             vunder,
    input  logic             timed_out,
    output logic             ena,
    output logic [2:0]       otrip,
    output logic [2:0]       vtrip,
    output logic             sys_resetb,
    output logic             bo_irq,
    output logic             bo_sticky,
    output logic             vu_sticky,
    output logic             to_sticky,
    output logic [CNT_W-1:0] bo_count,
    output logic             armed
);

    // A single flop cannot resolve metastability, so never build fewer than two stages.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ARM_W  = $clog2(ARM_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Bit order of the synchroniser word is {timed_out, vunder, outb}.
    // The idle pattern is the inactive level of each flag.
    localparam logic [2:0] SYNC_IDLE = 3'b001;

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        ARMING   = 3'd1,
        MONITOR  = 3'd2,
        BROWNOUT = 3'd3,
        RECOVER  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [DEB_W-1:0]  deb_reg, deb_next;
    logic [ARM_W-1:0]  arm_reg, arm_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              bo_event;
    logic              load_trip;
    logic              mon_trip;
    logic              clean;

    logic              ena_reg, sys_resetb_reg, armed_reg, bo_irq_reg;
    logic [2:0]        otrip_reg, vtrip_reg;
    logic              bo_sticky_reg, vu_sticky_reg, to_sticky_reg;
    logic [CNT_W-1:0]  bo_count_reg;

    logic [2:0]        sync_now;
    logic              outb_s, vunder_s, timed_out_s;

    // ------------------------------------------------------------------
    // Input synchronisers: one 3-bit stage per generate iteration
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_sync
            logic [2:0] q_reg;
            logic [2:0] d;
            if (gi == 0) begin : g_in
                assign d = {timed_out, vunder, outb};
            end else begin : g_chain
                assign d = g_sync[gi-1].q_reg;
            end
            // Shift stage, preset to the inactive level of each flag.
            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) q_reg <= SYNC_IDLE;
                else         q_reg <= d;
            end
        end
    endgenerate

    assign sync_now    = g_sync[STAGES-1].q_reg;
    assign outb_s      = sync_now[0];
    assign vunder_s    = sync_now[1];
    assign timed_out_s = sync_now[2];

`ifdef BROWNOUT_VUNDER_RESET_EN
    logic [DEB_W-1:0] vu_reg, vu_next;
    // Supply is healthy only when the detector is high and undervoltage is clear.
    assign clean    = outb_s & ~vunder_s;
    assign mon_trip = (!outb_s && deb_reg == DEB_LAST) || (vunder_s && vu_reg == DEB_LAST);
`else
    // Supply is healthy whenever the detector output is high.
    assign clean    = outb_s;
    assign mon_trip = !outb_s && deb_reg == DEB_LAST;
`endif

    // ------------------------------------------------------------------
    // FSM next-state, counter updates and event decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        deb_next   = deb_reg;
        arm_next   = arm_reg;
        hold_next  = hold_reg;
`ifdef BROWNOUT_VUNDER_RESET_EN
        vu_next    = vu_reg;
`endif
        bo_event   = 1'b0;
        load_trip  = 1'b0;
        case (state_reg)
            DISABLED: begin
                if (cfg_ena) begin
                    state_next = ARMING;
                    arm_next   = '0;
                    load_trip  = 1'b1;
                end
            end
            ARMING: begin
                // The detector output is not trusted here; only the settle timer runs.
                if (!cfg_ena) begin
                    state_next = DISABLED;
                end else if (arm_reg == ARM_LAST) begin
                    state_next = MONITOR;
                    deb_next   = '0;
`ifdef BROWNOUT_VUNDER_RESET_EN
                    vu_next    = '0;
`endif
                end else begin
                    arm_next = arm_reg + 1'b1;
                end
            end
            MONITOR: begin
                if (!cfg_ena) begin
                    state_next = DISABLED;
                end else begin
                    deb_next = outb_s ? '0 : deb_reg + 1'b1;
`ifdef BROWNOUT_VUNDER_RESET_EN
                    vu_next  = vunder_s ? vu_reg + 1'b1 : '0;
`endif
                    if (mon_trip) begin
                        state_next = BROWNOUT;
                        deb_next   = '0;
                        bo_event   = 1'b1;
                    end
                end
            end
            BROWNOUT: begin
                // Count consecutive healthy samples; any dip restarts the count.
                deb_next = clean ? deb_reg + 1'b1 : '0;
                if (clean && deb_reg == DEB_LAST) begin
                    state_next = RECOVER;
                    deb_next   = '0;
                    hold_next  = '0;
                end
            end
            RECOVER: begin
                // A dip during the hold wins over the terminal count. It is the
                // same event, so it raises no new irq and adds no count.
                if (!clean) begin
                    state_next = BROWNOUT;
                    deb_next   = '0;
                end else if (hold_reg == HOLD_LAST) begin
                    state_next = cfg_ena ? MONITOR : DISABLED;
                    deb_next   = '0;
`ifdef BROWNOUT_VUNDER_RESET_EN
                    vu_next    = '0;
`endif
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = DISABLED;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_reg <= DISABLED;
            deb_reg   <= '0;
            arm_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            deb_reg   <= deb_next;
            arm_reg   <= arm_next;
            hold_reg  <= hold_next;
        end
    end

`ifdef BROWNOUT_VUNDER_RESET_EN
    // Undervoltage debounce counter.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) vu_reg <= '0;
        else         vu_reg <= vu_next;
    end
`endif

    // Macro-facing and system outputs, registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ena_reg        <= 1'b0;
            sys_resetb_reg <= 1'b1;
            armed_reg      <= 1'b0;
            bo_irq_reg     <= 1'b0;
            otrip_reg      <= 3'd0;
            vtrip_reg      <= 3'd0;
        end else begin
            ena_reg        <= (state_next != DISABLED);
            sys_resetb_reg <= !((state_next == BROWNOUT) || (state_next == RECOVER));
            armed_reg      <= (state_next == MONITOR);
            bo_irq_reg     <= bo_event;
            if (load_trip) begin
                otrip_reg <= cfg_otrip;
                vtrip_reg <= cfg_vtrip;
            end
        end
    end

    // Sticky status and saturating event count; a set on the clear cycle wins.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            bo_sticky_reg <= 1'b0;
            vu_sticky_reg <= 1'b0;
            to_sticky_reg <= 1'b0;
            bo_count_reg  <= '0;
        end else begin
            if (bo_event)        bo_sticky_reg <= 1'b1;
            else if (status_clr) bo_sticky_reg <= 1'b0;

            if ((state_reg != DISABLED) && vunder_s) vu_sticky_reg <= 1'b1;
            else if (status_clr)                     vu_sticky_reg <= 1'b0;

            if ((state_reg != DISABLED) && timed_out_s) to_sticky_reg <= 1'b1;
            else if (status_clr)                        to_sticky_reg <= 1'b0;

            if (bo_event) begin
                if (status_clr)                  bo_count_reg <= CNT_W'(1);
                else if (bo_count_reg != CNT_MAX) bo_count_reg <= bo_count_reg + 1'b1;
            end else if (status_clr) begin
                bo_count_reg <= '0;
            end
        end
    end

    assign ena        = ena_reg;
    assign otrip      = otrip_reg;
    assign vtrip      = vtrip_reg;
    assign sys_resetb = sys_resetb_reg;
    assign bo_irq     = bo_irq_reg;
    assign bo_sticky  = bo_sticky_reg;
    assign vu_sticky  = vu_sticky_reg;
    assign to_sticky  = to_sticky_reg;
    assign bo_count   = bo_count_reg;
    assign armed      = armed_reg;

endmodule

// File: tb/tb_brownout_supervisor.sv
// tb_brownout_supervisor
// Directed bench for brownout_supervisor.
// Instance a uses default parameters. Instance b has short arm and hold times,
// so that 256 events fit in a short run.
// A behavioural model driven by pin history and run lengths predicts every
// output of both instances on every cycle. Literal expectations pin down the
// key latencies.
// Honours BROWNOUT_VUNDER_RESET_EN the same way as the design.
module tb_brownout_supervisor;

    localparam int DEB   = 8;
    localparam int OFF   = 0;
    localparam int SETTLE = 1;
    localparam int WATCH = 2;
    localparam int FAULT = 3;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       cfg_ena = 1'b0;
    logic [2:0] cfg_otrip = 3'd0;
    logic [2:0] cfg_vtrip = 3'd0;
    logic       status_clr = 1'b0;
    logic       outb = 1'b1;
    logic       vunder = 1'b0;
    logic       timed_out = 1'b0;

    logic       ena_a, sys_resetb_a, bo_irq_a, bo_sticky_a, vu_sticky_a, to_sticky_a, armed_a;
    logic [2:0] otrip_a, vtrip_a;
    logic [7:0] bo_count_a;
    logic       ena_b, sys_resetb_b, bo_irq_b, bo_sticky_b, vu_sticky_b, to_sticky_b, armed_b;
    logic [2:0] otrip_b, vtrip_b;
    logic [7:0] bo_count_b;

    int n_checks = 0;
    int n_bad = 0;
    int irq_seen_a = 0;

    always #5 clk = ~clk;

    brownout_supervisor u_dut (
        .clk(clk), .resetb(resetb), .cfg_ena(cfg_ena), .cfg_otrip(cfg_otrip),
        .cfg_vtrip(cfg_vtrip), .status_clr(status_clr), .outb(outb), .vunder(vunder),
        .timed_out(timed_out), .ena(ena_a), .otrip(otrip_a), .vtrip(vtrip_a),
        .sys_resetb(sys_resetb_a), .bo_irq(bo_irq_a), .bo_sticky(bo_sticky_a),
        .vu_sticky(vu_sticky_a), .to_sticky(to_sticky_a), .bo_count(bo_count_a),
        .armed(armed_a)
    );

    brownout_supervisor #(.ARM_CYCLES(4), .HOLD_CYCLES(8)) u_sat (
        .clk(clk), .resetb(resetb), .cfg_ena(cfg_ena), .cfg_otrip(cfg_otrip),
        .cfg_vtrip(cfg_vtrip), .status_clr(status_clr), .outb(outb), .vunder(vunder),
        .timed_out(timed_out), .ena(ena_b), .otrip(otrip_b), .vtrip(vtrip_b),
        .sys_resetb(sys_resetb_b), .bo_irq(bo_irq_b), .bo_sticky(bo_sticky_b),
        .vu_sticky(vu_sticky_b), .to_sticky(to_sticky_b), .bo_count(bo_count_b),
        .armed(armed_b)
    );

    function automatic int arm_of(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? 1024 : 8;
    endfunction

    // ---------------- behavioural model ----------------
    int         m_mode  [2] = '{OFF, OFF};
    int         m_entry [2] = '{0, 0};
    int         m_cnt   [2] = '{0, 0};
    logic [2:0] m_otrip [2] = '{3'd0, 3'd0};
    logic [2:0] m_vtrip [2] = '{3'd0, 3'd0};
    logic       m_irq   [2] = '{1'b0, 1'b0};
    logic       m_bo    [2] = '{1'b0, 1'b0};
    logic       m_vu    [2] = '{1'b0, 1'b0};
    logic       m_to    [2] = '{1'b0, 1'b0};
    logic [1:0] h_outb = 2'b11;
    logic [1:0] h_vu = 2'b00;
    logic [1:0] h_to = 2'b00;
    int         lo_run = 0, hi_run = 0, vu_run = 0, cyc = 0;
    logic       s_outb, s_vu, s_to, clean, trig, ev;
    int         since, old;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = OFF; m_entry[i] = 0; m_cnt[i] = 0;
                m_otrip[i] = 3'd0; m_vtrip[i] = 3'd0;
                m_irq[i] = 1'b0; m_bo[i] = 1'b0; m_vu[i] = 1'b0; m_to[i] = 1'b0;
            end
            h_outb = 2'b11; h_vu = 2'b00; h_to = 2'b00;
            lo_run = 0; hi_run = 0; vu_run = 0;
        end else begin
            // The value acted on at this edge is the pin as sampled two edges earlier.
            s_outb = h_outb[1]; s_vu = h_vu[1]; s_to = h_to[1];
            h_outb = {h_outb[0], outb};
            h_vu   = {h_vu[0], vunder};
            h_to   = {h_to[0], timed_out};
            cyc++;
`ifdef BROWNOUT_VUNDER_RESET_EN
            clean = s_outb && !s_vu;
`else
            clean = s_outb;
`endif
            lo_run = s_outb ? 0 : lo_run + 1;
            hi_run = clean ? hi_run + 1 : 0;
            vu_run = s_vu ? vu_run + 1 : 0;
            for (int i = 0; i < 2; i++) begin
                since = cyc - m_entry[i];
                old = m_mode[i];
                ev = 1'b0;
                trig = (lo_run >= DEB) && (since >= DEB);
`ifdef BROWNOUT_VUNDER_RESET_EN
                trig = trig || ((vu_run >= DEB) && (since >= DEB));
`endif
                if (old == OFF) begin
                    if (cfg_ena) begin
                        m_mode[i] = SETTLE; m_entry[i] = cyc;
                        m_otrip[i] = cfg_otrip; m_vtrip[i] = cfg_vtrip;
                    end
                end else if (old == SETTLE) begin
                    if (!cfg_ena) m_mode[i] = OFF;
                    else if (since == arm_of(i)) begin m_mode[i] = WATCH; m_entry[i] = cyc; end
                end else if (old == WATCH) begin
                    if (!cfg_ena) m_mode[i] = OFF;
                    else if (trig) begin m_mode[i] = FAULT; m_entry[i] = cyc; ev = 1'b1; end
                end else if (old == FAULT) begin
                    if (hi_run >= DEB && since >= DEB) begin m_mode[i] = HOLD; m_entry[i] = cyc; end
                end else begin
                    if (!clean) begin m_mode[i] = FAULT; m_entry[i] = cyc; end
                    else if (since == hold_of(i)) begin
                        m_mode[i] = cfg_ena ? WATCH : OFF; m_entry[i] = cyc;
                    end
                end
                m_irq[i] = ev;
                if (ev) begin
                    m_bo[i] = 1'b1;
                    m_cnt[i] = status_clr ? 1 : ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255);
                end else if (status_clr) begin
                    m_bo[i] = 1'b0; m_cnt[i] = 0;
                end
                if (old != OFF && s_vu) m_vu[i] = 1'b1;
                else if (status_clr)    m_vu[i] = 1'b0;
                if (old != OFF && s_to) m_to[i] = 1'b1;
                else if (status_clr)    m_to[i] = 1'b0;
            end
        end
    end

    function automatic logic [20:0] predict(input int i);
        return {m_mode[i] != OFF, m_otrip[i], m_vtrip[i],
                !(m_mode[i] == FAULT || m_mode[i] == HOLD), m_irq[i],
                m_bo[i], m_vu[i], m_to[i], 8'(m_cnt[i]), m_mode[i] == WATCH};
    endfunction

    logic [20:0] got_a, got_b, exp_a, exp_b;
    assign got_a = {ena_a, otrip_a, vtrip_a, sys_resetb_a, bo_irq_a, bo_sticky_a,
                    vu_sticky_a, to_sticky_a, bo_count_a, armed_a};
    assign got_b = {ena_b, otrip_b, vtrip_b, sys_resetb_b, bo_irq_b, bo_sticky_b,
                    vu_sticky_b, to_sticky_b, bo_count_b, armed_b};

    // Per-cycle comparison of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        exp_a = predict(0);
        exp_b = predict(1);
        n_checks++;
        if (got_a !== exp_a) begin
            n_bad++;
            $display("FAIL model_a t=%0t got=%h expected=%h", $time, got_a, exp_a);
        end
        n_checks++;
        if (got_b !== exp_b) begin
            n_bad++;
            $display("FAIL model_b t=%0t got=%h expected=%h", $time, got_b, exp_b);
        end
        if (bo_irq_a) irq_seen_a++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    int n;

    initial begin
        // Reset state
        tick(3);
        check("rst_ena", int'(ena_a), 0);
        check("rst_sys_resetb", int'(sys_resetb_a), 1);
        check("rst_count", int'(bo_count_a), 0);
        check("rst_armed", int'(armed_a), 0);
        resetb = 1'b1;
        tick(2);
        $display("step reset: ena=%0d sys_resetb=%0d", ena_a, sys_resetb_a);

        // Enable with trip codes; later cfg changes must be ignored
        cfg_ena = 1'b1; cfg_otrip = 3'b111; cfg_vtrip = 3'b101;
        tick(1);
        check("en_ena", int'(ena_a), 1);
        check("en_otrip", int'(otrip_a), 7);
        check("en_vtrip", int'(vtrip_a), 5);
        cfg_otrip = 3'd0; cfg_vtrip = 3'd2;
        tick(63);
        check("armed_early", int'(armed_a), 0);
        tick(1);
        check("armed_64", int'(armed_a), 1);
        check("otrip_held", int'(otrip_a), 7);
        $display("step enable: ena=%0d armed=%0d otrip=%0d vtrip=%0d", ena_a, armed_a, otrip_a, vtrip_a);

        // Glitch of seven low cycles is rejected
        outb = 1'b0; tick(7); outb = 1'b1; tick(16);
        check("glitch_count", int'(bo_count_a), 0);
        check("glitch_irq", irq_seen_a, 0);
        check("glitch_armed", int'(armed_a), 1);
        $display("step glitch: bo_count=%0d irq_seen=%0d", bo_count_a, irq_seen_a);

        // Full brown-out: reset asserts 2+8 edges after the pin falls
        outb = 1'b0;
        n = 0;
        while (sys_resetb_a && n < 40) begin tick(1); n++; end
        check("fall_latency", n, 10);
        if (n < 20) tick(20 - n);
        outb = 1'b1;
        check("bo_irq_once", irq_seen_a, 1);
        check("bo_count_1", int'(bo_count_a), 1);
        check("bo_sticky", int'(bo_sticky_a), 1);
        $display("step brownout: fall_latency=%0d bo_count=%0d", n, bo_count_a);

        // Re-dip at hold count 500, then a full debounce and hold
        tick(10 + 498);
        check("hold_active", int'(sys_resetb_a), 0);
        outb = 1'b0; tick(3); outb = 1'b1;
        n = 0;
        while (!sys_resetb_a && n < 1200) begin tick(1); n++; end
        check("rise_latency", n, 1034);
        check("redip_count", int'(bo_count_a), 1);
        check("redip_irq", irq_seen_a, 1);
        $display("step redip: rise_latency=%0d bo_count=%0d", n, bo_count_a);

        // Undervoltage for ten cycles in MONITOR
        vunder = 1'b1; tick(10); vunder = 1'b0; tick(6);
        check("vu_sticky", int'(vu_sticky_a), 1);
`ifdef BROWNOUT_VUNDER_RESET_EN
        check("vu_count", int'(bo_count_a), 2);
        check("vu_reset", int'(sys_resetb_a), 0);
`else
        check("vu_count", int'(bo_count_a), 1);
        check("vu_reset", int'(sys_resetb_a), 1);
`endif
        $display("step vunder: vu_sticky=%0d bo_count=%0d sys_resetb=%0d", vu_sticky_a, bo_count_a, sys_resetb_a);

        // timed_out sticky and a plain clear
        timed_out = 1'b1; tick(3); timed_out = 1'b0; tick(4);
        check("to_sticky", int'(to_sticky_a), 1);
        status_clr = 1'b1; tick(1); status_clr = 1'b0;
        check("clr_to", int'(to_sticky_a), 0);
        check("clr_vu", int'(vu_sticky_a), 0);
        check("clr_count", int'(bo_count_a), 0);
        $display("step clear: to=%0d vu=%0d bo_count=%0d", to_sticky_a, vu_sticky_a, bo_count_a);

        // Fresh start; then a disable from MONITOR drops ena on the next edge
        resetb = 1'b0; tick(2); resetb = 1'b1;
        tick(70);
        cfg_ena = 1'b0; tick(1);
        check("dis_ena_a", int'(ena_a), 0);
        check("dis_ena_b", int'(ena_b), 0);
        cfg_ena = 1'b1; tick(70);
        check("rearm_b", int'(armed_b), 1);
        $display("step disable: ena_a=%0d armed_b=%0d", ena_a, armed_b);

        // 256 events on the short instance
        for (int e = 0; e < 256; e++) begin
            outb = 1'b0; tick(12); outb = 1'b1; tick(20);
            $display("event %0d: bo_count_b=%0d", e + 1, bo_count_b);
        end
        check("sat_count", int'(bo_count_b), 255);
        check("sat_sticky", int'(bo_sticky_b), 1);

        // Clear on the exact edge of a new event: the set wins
        outb = 1'b0; tick(9); status_clr = 1'b1; tick(1); status_clr = 1'b0;
        check("coll_count", int'(bo_count_b), 1);
        check("coll_sticky", int'(bo_sticky_b), 1);
        check("coll_irq", int'(bo_irq_b), 1);
        $display("step collide: bo_count_b=%0d bo_sticky_b=%0d", bo_count_b, bo_sticky_b);

        // Asynchronous reset in BROWNOUT releases the system immediately
        tick(5);
        check("pre_rst_hold", int'(sys_resetb_a), 0);
        #2;
        resetb = 1'b0;
        #1;
        check("arst_sys_resetb_a", int'(sys_resetb_a), 1);
        check("arst_ena_a", int'(ena_a), 0);
        check("arst_sys_resetb_b", int'(sys_resetb_b), 1);
        check("arst_count_b", int'(bo_count_b), 0);
        $display("step async_reset: sys_resetb=%0d ena=%0d", sys_resetb_a, ena_a);
        outb = 1'b1;
        tick(3);
        resetb = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/brownout_supervisor.md
Name: brownout_supervisor

Overview:
- Digital supervisor on the far side of the brown-out detector's outputs.
- Drives the analog macro's ena, otrip[2:0] and vtrip[2:0].
- Receives the asynchronous outb, vunder and timed_out flags, synchronizes and debounces them, and issues a held system reset.
- Keeps sticky status and a saturating event counter for firmware.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each analog input (minimum 2).
- DEBOUNCE_CYCLES, 8, consecutive synchronized-low samples of outb needed to declare brown-out.
- ARM_CYCLES, 64, settle time after ena rises before the detector output is trusted.
- HOLD_CYCLES, 1024, sys_resetb low time after outb has been clean-high for DEBOUNCE_CYCLES.
- CNT_W, 8, width of the brown-out event counter.

Ports:
- clk  in  1  supervisor clock
- resetb  in  1  asynchronous active-low reset
- cfg_ena  in  1  firmware enable request
- cfg_otrip  in  3  requested brown-out trip code
- cfg_vtrip  in  3  requested undervoltage trip code
- status_clr  in  1  one-cycle pulse; clears sticky flags and counter
- outb  in  1  async from macro; low = brown-out
- vunder  in  1  async from macro; high = undervoltage
- timed_out  in  1  async from macro; high = oneshot expired
- ena  out  1  macro enable
- otrip  out  3  applied trip code to macro
- vtrip  out  3  applied trip code to macro
- sys_resetb  out  1  active-low system reset request
- bo_irq  out  1  one-cycle pulse on each new brown-out entry
- bo_sticky  out  1  brown-out seen since last clear
- vu_sticky  out  1  synchronized vunder seen high since last clear
- to_sticky  out  1  synchronized timed_out seen high since last clear
- bo_count  out  CNT_W  saturating brown-out event count
- armed  out  1  high in MONITOR state

Behaviour:
- Reset values:
  - ena=0, otrip=0, vtrip=0, sys_resetb=1, bo_irq=0, all sticky flags=0, bo_count=0, armed=0.
  - State = DISABLED; synchronizer chains preset to the inactive level (outb=1, vunder=0, timed_out=0).
- Inputs are used only after SYNC_STAGES flops. Latency from an input pin to a synchronized edge is SYNC_STAGES cycles.
- Trip codes:
  - otrip/vtrip are loaded from cfg_* only in DISABLED, on the cycle that cfg_ena is sampled high.
  - cfg_* changes while enabled are ignored until the next DISABLED pass.
- DISABLED:
  - ena=0, sys_resetb=1.
  - cfg_ena=1 -> ena=1 on the next edge, load trip codes, clear arm counter, go to ARMING.
- ARMING:
  - Count ARM_CYCLES; outb is ignored.
  - On terminal count -> MONITOR.
- MONITOR:
  - armed=1.
  - Debounce counter increments while synchronized outb=0 and resets to 0 on any outb=1 sample.
  - When it reaches DEBOUNCE_CYCLES:
    - go to BROWNOUT;
    - sys_resetb=0 on the same edge;
    - bo_irq=1 for one cycle;
    - bo_sticky=1;
    - bo_count+1, saturating at all-ones.
- BROWNOUT:
  - sys_resetb=0.
  - Count consecutive outb=1 samples; any 0 restarts the count.
  - At DEBOUNCE_CYCLES -> RECOVER with hold counter=0.
- RECOVER:
  - sys_resetb=0; hold counter increments each cycle.
  - Any synchronized outb=0 -> back to BROWNOUT. No new irq and no count increment; this is the same event.
  - At HOLD_CYCLES -> MONITOR, sys_resetb=1 on that edge.
- cfg_ena=0:
  - From ARMING or MONITOR: DISABLED next cycle, ena=0.
  - From BROWNOUT or RECOVER: the reset hold completes first, then DISABLED instead of MONITOR.
- Sticky flags:
  - vu_sticky and to_sticky set on synchronized high in any state except DISABLED.
- status_clr:
  - Clears all sticky flags and bo_count.
  - If a set condition occurs on the same cycle, the set wins: the flag becomes 1 and the count becomes 1.
- Asynchronous reset mid-operation returns every output to its reset value immediately, including releasing sys_resetb.

Optional Feature:
- Macro BROWNOUT_VUNDER_RESET_EN.
- When defined: synchronized vunder=1 for DEBOUNCE_CYCLES in MONITOR also enters BROWNOUT. The irq, sticky and count updates are identical to an outb event. The recovery debounce requires both outb=1 and vunder=0.
- When undefined: vunder only sets vu_sticky and never affects sys_resetb.

Test Plan:
- Reset and enable (defaults):
  - Stimulus: reset, then cfg_ena=1 with cfg_otrip=3'b111, cfg_vtrip=3'b101.
  - Required: ena=1 one cycle later, otrip=7, vtrip=5; armed=1 after 64 cycles; sys_resetb stays 1 throughout.
- Glitch rejection:
  - Stimulus: in MONITOR, outb low for 7 cycles, then high.
  - Required: no state change, bo_count=0, bo_irq never pulses.
- Full brown-out:
  - Stimulus: outb low 20 cycles, then high.
  - Required: sys_resetb falls 2+8 cycles after outb falls; bo_irq pulses once; bo_count=1. sys_resetb rises 8+1024 cycles after synchronized outb rises.
- Re-dip during RECOVER:
  - Stimulus: outb low again at hold count 500.
  - Required: return to BROWNOUT, bo_count stays 1, full 1024-cycle hold restarts after the clean debounce.
- Saturation and clear priority:
  - Stimulus: 256 events with CNT_W=8; then status_clr on the same cycle as a new event.
  - Required: count holds at 255; after the colliding clear, bo_count=1 and bo_sticky=1.
- Async reset and macro test:
  - Stimulus: assert resetb during BROWNOUT; separately, drive vunder high for 10 cycles in MONITOR.
  - Required: reset releases sys_resetb=1 and ena=0 immediately. With BROWNOUT_VUNDER_RESET_EN the vunder pulse causes reset entry; without it, only vu_sticky=1.
